zoled_spi_sink: RTL and testbench
=================================

ZOLED_SPI_SINK -- requirements
Module: zoled_spi_sink

Interface
REQ-001 Parameter SYNC_STAGES, default 2, input synchronizer depth for cs_n/sclk/dc/sdin.
REQ-002 Parameter CONTRAST_RST, default 8'h7F, reset value of contrast.
REQ-003 clk  input  1  system clock; SHALL be at least 4x the sclk frequency.
REQ-004 rst_n  input  1  reset: asynchronous, active-low.
REQ-005 cs_n  input  1  SPI chip select, active-low.
REQ-006 sclk  input  1  SPI clock; data sampled on its rising edge.
REQ-007 dc  input  1  0 = command byte, 1 = GRAM data byte.
REQ-008 sdin  input  1  SPI MOSI, MSB first.
REQ-009 oled_rst  input  1  panel reset from the controller, active-low.
REQ-010 wr_en  output  1  one-cycle pulse: GRAM byte write.
REQ-011 wr_addr  output  10  GRAM address = {page[2:0], col[6:0]}.
REQ-012 wr_data  output  8  GRAM byte; bit0 = top pixel row of the page.
REQ-013 cmd_valid  output  1  one-cycle pulse: command byte received.
REQ-014 cmd_byte  output  8  last command byte; held until the next one.
REQ-015 disp_on  output  1  display on/off state.
REQ-016 contrast  output  8  contrast register.
REQ-017 page  output  3  current page pointer.
REQ-018 col  output  7  current column pointer.
REQ-019 frame_err  output  1  sticky: cs_n deasserted with 1-7 bits pending.

Function
REQ-020 SHALL pass cs_n, sclk, dc, sdin and oled_rst through SYNC_STAGES flops, then detect the sclk rise as a 0->1 change between consecutive synchronized samples.
REQ-021 On each detected rise with synchronized cs_n=0: shift sdin into an 8-bit register MSB first; bit counter +1.
REQ-022 On the 8th rise: latch dc; byte complete; counter wraps to 0.
REQ-023 Byte complete SHALL assert exactly one cycle of wr_en or cmd_valid in the clk cycle after the 8th rise is detected.
REQ-024 Synchronized cs_n=1 SHALL clear the bit counter; if the counter was 1-7, set frame_err; partial byte discarded; no pulse.
REQ-025 Decoder FSM states: IDLE, ARG_CONTRAST. Reset state IDLE.
REQ-026 IDLE, data byte: wr_en=1, wr_addr={page,col}, wr_data=byte; then col = col+1 mod 128; page unchanged.
REQ-027 IDLE, command 8'h00-8'h0F: col[3:0] = byte[3:0].
REQ-028 IDLE, command 8'h10-8'h17: col[6:4] = byte[2:0]; 8'h18-8'h1F: cmd_valid only.
REQ-029 IDLE, command 8'hB0-8'hB7: page = byte[2:0].
REQ-030 IDLE, command 8'hAE/8'hAF: disp_on = byte[0].
REQ-031 IDLE, command 8'h81: go to ARG_CONTRAST.
REQ-032 ARG_CONTRAST, next byte of either dc: contrast = byte, cmd_valid=1, go to IDLE; no GRAM write.
REQ-033 Any other command: cmd_valid and cmd_byte update only; no state change.
REQ-034 cmd_valid SHALL pulse for every command byte, including 8'h81 and its argument.
REQ-035 wr_en and cmd_valid SHALL never assert in the same cycle.
REQ-036 Pointer updates SHALL become visible on page/col in the same cycle as the pulse.

Reset
REQ-037 rst_n low, asynchronously: wr_en=0, cmd_valid=0, cmd_byte=0, wr_addr=0, wr_data=0, disp_on=0, contrast=CONTRAST_RST, page=0, col=0, frame_err=0, FSM=IDLE, shift register and counter=0.
REQ-038 Synchronized oled_rst=0 SHALL apply the same values synchronously, excluding the synchronizer flops; bytes in flight are dropped without frame_err.

Structure
REQ-039 Shared package zoled_pkg: command opcode constants (8'hAE, 8'hAF, 8'h81, 8'hB0 page base, 8'h00/8'h10 column nibble bases) and FSM state encoding, also used by the command list.
REQ-040 One sub-module: zspi_byte_rx (synchronizer, edge detect, shift register, bit count, frame_err); zoled_spi_sink holds the decoder FSM and pointers.

Verification
REQ-041 Bench SHALL model SPI mode 0 at sclk = clk/8, MSB first.
REQ-042 Send commands B2, 05, 13, then data 3C -> wr_en once with wr_addr=10'h135, wr_data=8'h3C; col=7'h36 afterwards.
REQ-043 Send command B1 with col at 127, then data AA, 55 -> writes at addresses 10'h0FF and 10'h080; page stays 1.
REQ-044 Send command 81 followed by a data-phase byte 40 -> contrast=8'h40, no wr_en, cmd_valid twice, FSM in IDLE.
REQ-045 Drop cs_n after 5 bits, then send a full command AF -> frame_err=1, no pulse for the partial byte, disp_on=1.
REQ-046 Pulse oled_rst low for 3 cycles in the middle of a data byte -> page=0, col=0, contrast=8'h7F, no wr_en, frame_err=0.
REQ-047 Drive the controller command list (init, clear, 6 glyphs) at the SPI pins -> wr_en count equals that list's total data byte count; all addresses in range.

Source files
------------

// File: rtl/zoled_pkg.sv
// Shared opcodes, decoder state encoding and register bundle for the OLED SPI sink.
// The controller command list is built from the same opcode constants.
package zoled_pkg;

  localparam logic [7:0] CmdColLoBase   = 8'h00;
  localparam logic [7:0] CmdColHiBase   = 8'h10;
  localparam logic [7:0] CmdSetContrast = 8'h81;
  localparam logic [7:0] CmdDispOff     = 8'hAE;
  localparam logic [7:0] CmdDispOn      = 8'hAF;
  localparam logic [7:0] CmdPageBase    = 8'hB0;

  typedef enum logic [0:0] {
    StIdle,
    StArgContrast
  } dec_state_e;

  typedef enum logic [2:0] {
    OpColLo,
    OpColHi,
    OpPage,
    OpDisp,
    OpContrast,
    OpOther
  } cmd_op_e;

  typedef struct packed {
    dec_state_e  state;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        cmd_valid;
    logic [7:0]  cmd_byte;
    logic        disp_on;
    logic [7:0]  contrast;
    logic [2:0]  page;
    logic [6:0]  col;
  } sink_regs_t;

  // 0x18-0x1F share the column-high prefix bits but are not column commands.
  function automatic cmd_op_e decode_cmd(input logic [7:0] b);
    cmd_op_e op;
    op = OpOther;
    if (b[7:4] == CmdColLoBase[7:4]) begin
      op = OpColLo;
    end else if (b[7:3] == CmdColHiBase[7:3]) begin
      op = OpColHi;
    end else if (b[7:3] == CmdPageBase[7:3]) begin
      op = OpPage;
    end else if (b[7:1] == CmdDispOff[7:1]) begin
      op = OpDisp;
    end else if (b == CmdSetContrast) begin
      op = OpContrast;
    end
    return op;
  endfunction

endpackage

// File: rtl/zoled_spi_sink_if.sv
// SPI pin bundle plus the GRAM write / command strobe port of the OLED sink.
interface zoled_spi_sink_if;
  logic       cs_n;
  logic       sclk;
  logic       dc;
  logic       sdin;
  logic       oled_rst;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic       cmd_valid;
  logic [7:0] cmd_byte;

  modport master (
    output cs_n, sclk, dc, sdin, oled_rst,
    input  wr_en, wr_addr, wr_data, cmd_valid, cmd_byte
  );

  modport slave (
    input  cs_n, sclk, dc, sdin, oled_rst,
    output wr_en, wr_addr, wr_data, cmd_valid, cmd_byte
  );
endinterface

// File: rtl/zspi_byte_rx.sv
// SPI mode-0 byte receiver: input synchronizers, sclk rise detect, MSB-first shifter,
// bit counter and sticky framing error. byte_done is combinational in the 8th-rise cycle.
module zspi_byte_rx
  import zoled_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic       sclk,
    input  logic       dc,
    input  logic       sdin,
    input  logic       oled_rst,
    output logic       soft_rst,
    output logic       byte_done,
    output logic       byte_dc,
    output logic [7:0] byte_data,
    output logic       frame_err
);

  // Bit order {oled_rst, cs_n, sclk, dc, sdin}; idle levels keep the sink deselected.
  localparam logic [4:0] SyncIdle = 5'b11000;

  logic [4:0] sync_q [SYNC_STAGES];
  logic       oled_rst_s, cs_n_s, sclk_s, dc_s, sdin_s;
  logic       sclk_prev_q;
  logic       rise;
  logic [7:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic       frame_err_q, frame_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= SyncIdle;
      end
      sclk_prev_q <= 1'b0;
    end else begin
      sync_q[0] <= {oled_rst, cs_n, sclk, dc, sdin};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      sclk_prev_q <= sclk_s;
    end
  end

  assign {oled_rst_s, cs_n_s, sclk_s, dc_s, sdin_s} = sync_q[SYNC_STAGES-1];

  assign rise      = sclk_s & ~sclk_prev_q;
  assign soft_rst  = ~oled_rst_s;
  assign byte_done = oled_rst_s & ~cs_n_s & rise & (cnt_q == 3'd7);
  assign byte_dc   = dc_s;
  assign byte_data = {shift_q[6:0], sdin_s};
  assign frame_err = frame_err_q;

  always_comb begin
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    frame_err_d = frame_err_q;
    if (!oled_rst_s) begin
      shift_d     = '0;
      cnt_d       = '0;
      frame_err_d = 1'b0;
    end else if (cs_n_s) begin
      shift_d = '0;
      cnt_d   = '0;
      if (cnt_q != 3'd0) begin
        frame_err_d = 1'b1;
      end
    end else if (rise) begin
      shift_d = {shift_q[6:0], sdin_s};
      cnt_d   = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q     <= '0;
      cnt_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule

// File: rtl/zoled_spi_sink.sv
// SSD1306-style SPI sink: byte receiver plus command decoder, page/column pointers,
// GRAM write strobe and display/contrast state.
module zoled_spi_sink
  import zoled_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter logic [7:0]  CONTRAST_RST = 8'h7F
) (
    input  logic                   clk,
    input  logic                   rst_n,
    zoled_spi_sink_if.slave        bus,
    output logic                   disp_on,
    output logic [7:0]             contrast,
    output logic [2:0]             page,
    output logic [6:0]             col,
    output logic                   frame_err
);

  localparam sink_regs_t RegsRst = '{
    state:     StIdle,
    wr_en:     1'b0,
    wr_addr:   10'd0,
    wr_data:   8'd0,
    cmd_valid: 1'b0,
    cmd_byte:  8'd0,
    disp_on:   1'b0,
    contrast:  CONTRAST_RST,
    page:      3'd0,
    col:       7'd0
  };

  logic       soft_rst;
  logic       byte_done;
  logic       byte_dc;
  logic [7:0] byte_data;

  sink_regs_t regs_q, regs_d;

  zspi_byte_rx #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .cs_n      (bus.cs_n),
    .sclk      (bus.sclk),
    .dc        (bus.dc),
    .sdin      (bus.sdin),
    .oled_rst  (bus.oled_rst),
    .soft_rst  (soft_rst),
    .byte_done (byte_done),
    .byte_dc   (byte_dc),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  always_comb begin
    regs_d           = regs_q;
    regs_d.wr_en     = 1'b0;
    regs_d.cmd_valid = 1'b0;
    if (soft_rst) begin
      regs_d = RegsRst;
    end else if (byte_done) begin
      if (regs_q.state == StArgContrast) begin
        // Argument is taken regardless of dc and never reaches GRAM.
        regs_d.contrast  = byte_data;
        regs_d.cmd_valid = 1'b1;
        regs_d.cmd_byte  = byte_data;
        regs_d.state     = StIdle;
      end else if (byte_dc) begin
        regs_d.wr_en   = 1'b1;
        regs_d.wr_addr = {regs_q.page, regs_q.col};
        regs_d.wr_data = byte_data;
        regs_d.col     = regs_q.col + 7'd1;
      end else begin
        regs_d.cmd_valid = 1'b1;
        regs_d.cmd_byte  = byte_data;
        case (decode_cmd(byte_data))
          OpColLo:    regs_d.col[3:0] = byte_data[3:0];
          OpColHi:    regs_d.col[6:4] = byte_data[2:0];
          OpPage:     regs_d.page     = byte_data[2:0];
          OpDisp:     regs_d.disp_on  = byte_data[0];
          OpContrast: regs_d.state    = StArgContrast;
          default:    ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= RegsRst;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign bus.wr_en     = regs_q.wr_en;
  assign bus.wr_addr   = regs_q.wr_addr;
  assign bus.wr_data   = regs_q.wr_data;
  assign bus.cmd_valid = regs_q.cmd_valid;
  assign bus.cmd_byte  = regs_q.cmd_byte;
  assign disp_on       = regs_q.disp_on;
  assign contrast      = regs_q.contrast;
  assign page          = regs_q.page;
  assign col           = regs_q.col;

  a_no_dual_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    !(regs_q.wr_en && regs_q.cmd_valid));

endmodule

// File: tb/tb_zoled_spi_sink.sv
// Directed bench for zoled_spi_sink: SPI mode 0 at clk/8, table of byte vectors,
// framing/soft-reset sequences and a full controller command list.
module tb_zoled_spi_sink;
  import zoled_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  zoled_spi_sink_if bus ();

  logic       disp_on;
  logic [7:0] contrast;
  logic [2:0] page;
  logic [6:0] col;
  logic       frame_err;

  zoled_spi_sink #(
    .SYNC_STAGES (2),
    .CONTRAST_RST(8'h7F)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .disp_on  (disp_on),
    .contrast (contrast),
    .page     (page),
    .col      (col),
    .frame_err(frame_err)
  );

  int n_checks = 0;
  int n_fail = 0;

  int wr_cnt = 0;
  int cmd_cnt = 0;
  int both_cnt = 0;
  int addr_mis = 0;
  int range_err = 0;
  logic list_mode = 1'b0;
  logic [9:0] exp_addr_q[$];

  always @(negedge clk) begin
    if (bus.wr_en) begin
      wr_cnt++;
      if (list_mode) begin
        if (exp_addr_q.size() == 0) addr_mis++;
        else if (bus.wr_addr !== exp_addr_q.pop_front()) addr_mis++;
        if (bus.wr_addr[9:7] >= 3'd4) range_err++;
      end
    end
    if (bus.cmd_valid) cmd_cnt++;
    if (bus.wr_en && bus.cmd_valid) both_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b);
    bus.sclk = 1'b0;
    bus.sdin = b;
    wait_clk(4);
    bus.sclk = 1'b1;
    wait_clk(4);
  endtask

  task automatic spi_byte(input logic d, input logic [7:0] b);
    bus.cs_n = 1'b0;
    bus.dc   = d;
    wait_clk(4);
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
    bus.sclk = 1'b0;
    wait_clk(4);
    bus.cs_n = 1'b1;
    wait_clk(4);
  endtask

  typedef struct {
    logic       dc;
    logic [7:0] b;
    int         wr;
    int         cmd;
    logic [9:0] addr;
    logic [7:0] wdata;
    logic [2:0] page;
    logic [6:0] col;
    logic       disp;
    logic [7:0] con;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input logic d, input logic [7:0] b, input int wr, input int cmd,
                              input logic [9:0] addr, input logic [7:0] wdata,
                              input logic [2:0] pg, input logic [6:0] cl, input logic disp,
                              input logic [7:0] con);
    vec_t v;
    v.dc = d; v.b = b; v.wr = wr; v.cmd = cmd; v.addr = addr; v.wdata = wdata;
    v.page = pg; v.col = cl; v.disp = disp; v.con = con;
    return v;
  endfunction

  initial begin
    int w0, c0;
    logic [6:0] gc;

    tbl[0]  = mk(0, 8'hB2, 0, 1, 10'h000, 8'h00, 3'd2, 7'h00, 0, 8'h7F);
    tbl[1]  = mk(0, 8'h05, 0, 1, 10'h000, 8'h00, 3'd2, 7'h05, 0, 8'h7F);
    tbl[2]  = mk(0, 8'h13, 0, 1, 10'h000, 8'h00, 3'd2, 7'h35, 0, 8'h7F);
    tbl[3]  = mk(1, 8'h3C, 1, 0, 10'h135, 8'h3C, 3'd2, 7'h36, 0, 8'h7F);
    tbl[4]  = mk(0, 8'h0F, 0, 1, 10'h000, 8'h00, 3'd2, 7'h3F, 0, 8'h7F);
    tbl[5]  = mk(0, 8'h17, 0, 1, 10'h000, 8'h00, 3'd2, 7'h7F, 0, 8'h7F);
    tbl[6]  = mk(0, 8'hB1, 0, 1, 10'h000, 8'h00, 3'd1, 7'h7F, 0, 8'h7F);
    tbl[7]  = mk(1, 8'hAA, 1, 0, 10'h0FF, 8'hAA, 3'd1, 7'h00, 0, 8'h7F);
    tbl[8]  = mk(1, 8'h55, 1, 0, 10'h080, 8'h55, 3'd1, 7'h01, 0, 8'h7F);
    tbl[9]  = mk(0, 8'h81, 0, 1, 10'h000, 8'h00, 3'd1, 7'h01, 0, 8'h7F);
    tbl[10] = mk(1, 8'h40, 0, 1, 10'h000, 8'h00, 3'd1, 7'h01, 0, 8'h40);
    tbl[11] = mk(1, 8'h11, 1, 0, 10'h081, 8'h11, 3'd1, 7'h02, 0, 8'h40);
    tbl[12] = mk(0, 8'hAF, 0, 1, 10'h000, 8'h00, 3'd1, 7'h02, 1, 8'h40);
    tbl[13] = mk(0, 8'h1A, 0, 1, 10'h000, 8'h00, 3'd1, 7'h02, 1, 8'h40);
    tbl[14] = mk(0, 8'hA5, 0, 1, 10'h000, 8'h00, 3'd1, 7'h02, 1, 8'h40);
    tbl[15] = mk(0, 8'hAE, 0, 1, 10'h000, 8'h00, 3'd1, 7'h02, 0, 8'h40);

    bus.cs_n = 1'b1;
    bus.sclk = 1'b0;
    bus.dc = 1'b0;
    bus.sdin = 1'b0;
    bus.oled_rst = 1'b1;

    // Reset values while rst_n is held low
    wait_clk(4);
    check("rst wr_en", 32'(bus.wr_en), 0);
    check("rst cmd_valid", 32'(bus.cmd_valid), 0);
    check("rst cmd_byte", 32'(bus.cmd_byte), 0);
    check("rst wr_addr", 32'(bus.wr_addr), 0);
    check("rst wr_data", 32'(bus.wr_data), 0);
    check("rst disp_on", 32'(disp_on), 0);
    check("rst contrast", 32'(contrast), 32'h7F);
    check("rst page", 32'(page), 0);
    check("rst col", 32'(col), 0);
    check("rst frame_err", 32'(frame_err), 0);
    rst_n = 1'b1;
    wait_clk(10);

    for (int i = 0; i < 16; i++) begin
      w0 = wr_cnt;
      c0 = cmd_cnt;
      spi_byte(tbl[i].dc, tbl[i].b);
      check($sformatf("row%0d wr_en count", i), 32'(wr_cnt - w0), 32'(tbl[i].wr));
      check($sformatf("row%0d cmd_valid count", i), 32'(cmd_cnt - c0), 32'(tbl[i].cmd));
      check($sformatf("row%0d page", i), 32'(page), 32'(tbl[i].page));
      check($sformatf("row%0d col", i), 32'(col), 32'(tbl[i].col));
      check($sformatf("row%0d disp_on", i), 32'(disp_on), 32'(tbl[i].disp));
      check($sformatf("row%0d contrast", i), 32'(contrast), 32'(tbl[i].con));
      if (tbl[i].wr != 0) begin
        check($sformatf("row%0d wr_addr", i), 32'(bus.wr_addr), 32'(tbl[i].addr));
        check($sformatf("row%0d wr_data", i), 32'(bus.wr_data), 32'(tbl[i].wdata));
      end
      if (tbl[i].cmd != 0) begin
        check($sformatf("row%0d cmd_byte", i), 32'(bus.cmd_byte), 32'(tbl[i].b));
      end
    end
    check("frame_err clean", 32'(frame_err), 0);

    // Partial byte: 5 bits then deselect
    w0 = wr_cnt;
    c0 = cmd_cnt;
    bus.cs_n = 1'b0;
    bus.dc = 1'b0;
    wait_clk(4);
    for (int i = 0; i < 5; i++) spi_bit(i[0]);
    bus.sclk = 1'b0;
    wait_clk(4);
    bus.cs_n = 1'b1;
    wait_clk(8);
    check("partial frame_err", 32'(frame_err), 1);
    check("partial no wr_en", 32'(wr_cnt - w0), 0);
    check("partial no cmd_valid", 32'(cmd_cnt - c0), 0);
    spi_byte(1'b0, CmdDispOn);
    check("after partial disp_on", 32'(disp_on), 1);
    check("after partial cmd count", 32'(cmd_cnt - c0), 1);
    check("after partial cmd_byte", 32'(bus.cmd_byte), 32'hAF);
    check("frame_err sticky", 32'(frame_err), 1);

    // Panel reset mid data byte
    w0 = wr_cnt;
    bus.cs_n = 1'b0;
    bus.dc = 1'b1;
    wait_clk(4);
    for (int i = 0; i < 4; i++) spi_bit(1'b1);
    bus.sclk = 1'b0;
    wait_clk(2);
    bus.oled_rst = 1'b0;
    wait_clk(3);
    bus.oled_rst = 1'b1;
    wait_clk(8);
    bus.cs_n = 1'b1;
    wait_clk(8);
    check("oled_rst page", 32'(page), 0);
    check("oled_rst col", 32'(col), 0);
    check("oled_rst contrast", 32'(contrast), 32'h7F);
    check("oled_rst disp_on", 32'(disp_on), 0);
    check("oled_rst frame_err", 32'(frame_err), 0);
    check("oled_rst no wr_en", 32'(wr_cnt - w0), 0);
    check("oled_rst cmd_byte", 32'(bus.cmd_byte), 0);

    // Controller command list: init, clear 4 pages, 6 glyphs on page 1
    w0 = wr_cnt;
    list_mode = 1'b1;
    spi_byte(1'b0, CmdDispOff);
    spi_byte(1'b0, CmdSetContrast);
    spi_byte(1'b0, 8'hCF);
    spi_byte(1'b0, 8'hA1);
    spi_byte(1'b0, 8'hC8);
    spi_byte(1'b0, 8'hA6);
    spi_byte(1'b0, CmdDispOn);
    for (int p = 0; p < 4; p++) begin
      spi_byte(1'b0, CmdPageBase | 8'(p));
      spi_byte(1'b0, CmdColLoBase);
      spi_byte(1'b0, CmdColHiBase);
      for (int c = 0; c < 128; c++) begin
        exp_addr_q.push_back(10'(p * 128 + c));
        spi_byte(1'b1, 8'h00);
      end
    end
    for (int g = 0; g < 6; g++) begin
      gc = 7'(10 + 6 * g);
      spi_byte(1'b0, CmdPageBase | 8'h01);
      spi_byte(1'b0, CmdColLoBase | {4'h0, gc[3:0]});
      spi_byte(1'b0, CmdColHiBase | {5'h00, gc[6:4]});
      for (int k = 0; k < 5; k++) begin
        exp_addr_q.push_back(10'(128 + int'(gc) + k));
        spi_byte(1'b1, 8'(g * 16 + k + 1));
      end
    end
    wait_clk(8);
    list_mode = 1'b0;
    check("list wr_en count", 32'(wr_cnt - w0), 32'd542);
    check("list address mismatches", 32'(addr_mis), 0);
    check("list addresses out of range", 32'(range_err), 0);
    check("list pending addresses", 32'(exp_addr_q.size()), 0);
    check("list contrast", 32'(contrast), 32'hCF);
    check("list disp_on", 32'(disp_on), 1);
    check("list page", 32'(page), 1);
    check("list col", 32'(col), 32'd45);
    check("wr_en with cmd_valid cycles", 32'(both_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
